mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore-style main controller that sequences a multicycle MIPS datapath (shared memory, IR, ALU, regfile, PC) one instruction at a time.
- Decodes opcode/funct from the IR and drives all mux selects, write enables and the 4-bit ALU function code.
- Stalls on a memory-ready handshake and keeps a retired-instruction counter.
- Sits beside the datapath top level, replacing the single-cycle combinational control unit.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_WAIT_MAX, 15, max stall cycles before timeout flag; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; state -> FETCH, counters cleared
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_write  out  1  data memory write strobe
ir_write  out  1  IR load enable
pc_write_en  out  1  final PC enable (pc_write | branch-taken)
pc_src  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 PC, 1 RD1
alu_src_b  out  2  00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2
alu_control  out  4  ALU F code
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  regfile write enable
illegal  out  1  one-cycle pulse on unsupported opcode/funct
mem_timeout  out  1  sticky; set when a stall exceeds MEM_WAIT_MAX
state_dbg  out  4  current state encoding
retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding (state_dbg):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Codes 12-15 are unreachable; if entered -> FETCH next cycle.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Default for every output not listed for a state: 0 (alu_control defaults to ADD).
- FETCH:
  - Drives i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - ir_write and pc_write_en = mem_ready (Mealy gating).
  - Advances to DECODE only when mem_ready=1; otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, ADD. Next state by opcode:
  - lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode -> illegal=1 this cycle, next FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD; lw -> MEMRD, sw -> MEMWR.
- MEMRD: i_or_d=1; hold until mem_ready, then -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: i_or_d=1, mem_write=1 held until mem_ready, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct.
  - Supported funct -> ALUWB.
  - Unknown funct -> illegal=1, -> FETCH; no register write.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; pc_write_en=zero -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_write_en=1 -> FETCH.
- retired:
  - Increments by 1 on every transition from a terminal state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP) into FETCH.
  - Illegal aborts do not count.
  - Wraps modulo 2^CNT_W.
- Stall counter:
  - Counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR; clears when mem_ready=1 or the state changes.
  - Reaching MEM_WAIT_MAX sets mem_timeout (sticky until reset). FSM keeps waiting.
- Reset asserted, including mid-instruction:
  - Immediately state=FETCH; retired=0; mem_timeout=0; stall count=0.
  - All write strobes (mem_write, ir_write, pc_write_en, reg_write) forced 0 while reset is high.
  - Mux selects take their FETCH values.

Optional Feature:
MIPS_CTRL_BNE_EN
- Defined: opcode 000101 (bne) decodes to BRANCH; pc_write_en = ~zero for bne, zero for beq. Opcode is latched in DECODE to make this distinction.
- Undefined: 000101 is illegal (pulse, return to FETCH).

Test Plan:
- reset high mid-MEMRD, release -> state_dbg=0, retired=0, all strobes 0 during reset.
- add (opcode 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 in ALUWB; retired=1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1; 8 total cycles; mem_timeout stays 0.
- beq zero=1 then zero=0 -> pc_write_en=1 with pc_src=01 in first BRANCH, 0 in second; both retire.
- opcode 111111 -> illegal pulses 1 cycle in DECODE, back to FETCH, retired unchanged; funct 000001 under R-type -> illegal in EXEC, reg_write never 1.
- MEM_WAIT_MAX=3, mem_ready held 0 in FETCH 5 cycles -> mem_timeout=1 from 4th stall cycle, FETCH held; with MIPS_CTRL_BNE_EN, bne zero=0 -> pc_write_en=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             i_or_d;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write_en;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_control;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             illegal;
  logic             mem_timeout;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output i_or_d, mem_write, ir_write, pc_write_en, pc_src, alu_src_a, alu_src_b,
           alu_control, reg_dst, mem_to_reg, reg_write, illegal, mem_timeout,
           state_dbg, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  i_or_d, mem_write, ir_write, pc_write_en, pc_src, alu_src_a, alu_src_b,
           alu_control, reg_dst, mem_to_reg, reg_write, illegal, mem_timeout,
           state_dbg, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: FSM sequencing, memory-stall watchdog, retired counter.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);
  // states: 0 FETCH | 1 DECODE | 2 MEMADR | 3 MEMRD | 4 MEMWB | 5 MEMWR | 6 EXEC | 7 ALUWB
  //         8 BRANCH | 9 ADDIEX | 10 ADDIWB | 11 JUMP | 12-15 unreachable, recover to FETCH
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int SW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MEM_WAIT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             timeout_q, timeout_d;
`ifdef MIPS_CTRL_BNE_EN
  logic             bne_q, bne_d;
`endif

  logic       i_or_d, mem_write, ir_write, pc_write, alu_src_a;
  logic       reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_control;
  logic       branch_taken;
  logic       stalling;
  logic       retire;

`ifdef MIPS_CTRL_BNE_EN
  assign branch_taken = bne_q ? ~bus.zero : bus.zero;
`else
  assign branch_taken = bus.zero;
`endif

  always_comb begin
    state_d     = state_q;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        state_d   = ALUWB;
        case (bus.funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = branch_taken;
        state_d     = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Stall run length saturates at the limit; the sticky flag rises on the cycle it is reached.
  assign stalling  = (state_q inside {FETCH, MEMRD, MEMWR}) && !bus.mem_ready;
  assign stall_d   = !stalling ? '0 : (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
  assign timeout_d = timeout_q | ((MEM_WAIT_MAX != 0) && stalling && (stall_d == STALL_MAX));

  assign retire    = (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP}) &&
                     (state_d == FETCH);
  assign retired_d = retired_q + CNT_W'(retire);

`ifdef MIPS_CTRL_BNE_EN
  assign bne_d = (state_q == DECODE) ? (bus.opcode == OP_BNE) : bne_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= bne_d;
`endif
    end
  end

  // Strobes are held off for the whole reset window, not just until the first edge.
  assign bus.mem_write   = mem_write & ~reset;
  assign bus.ir_write    = ir_write  & ~reset;
  assign bus.pc_write_en = pc_write  & ~reset;
  assign bus.reg_write   = reg_write & ~reset;
  assign bus.i_or_d      = i_or_d;
  assign bus.pc_src      = pc_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_control = alu_control;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.illegal     = illegal;
  assign bus.mem_timeout = timeout_q;
  assign bus.state_dbg   = state_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-scenario tasks with hand-computed expectations.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W        = 4;
  localparam int MEM_WAIT_MAX = 15;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [CNT_W-1:0] exp_ret;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #2;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 4'd0 || bus.mem_timeout !== 1'b0) begin
      $display("FAIL reset_init got st=%0d ret=%0d to=%0b exp 0 0 0", bus.state_dbg, bus.retired, bus.mem_timeout); bad++;
    end
    total++;
    if ({bus.mem_write, bus.ir_write, bus.pc_write_en, bus.reg_write} !== 4'b0000) begin
      $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_write, bus.ir_write, bus.pc_write_en, bus.reg_write}); bad++;
    end
    next();
    reset = 1'b0;
    #1;
    total++;
    if (bus.ir_write !== 1'b1) begin $display("FAIL fetch_ir_write got=%b exp=1", bus.ir_write); bad++; end
    next(); next();
    bus.mem_ready = 1'b0;
    next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd3 || bus.i_or_d !== 1'b1) begin
      $display("FAIL pre_reset_memrd got st=%0d iord=%b exp st=3 iord=1", bus.state_dbg, bus.i_or_d); bad++;
    end
    reset = 1'b1; bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.i_or_d !== 1'b0 || bus.alu_src_b !== 2'b01 || bus.alu_control !== 4'b0010) begin
      $display("FAIL async_reset got st=%0d iord=%b srcb=%b alu=%b exp 0 0 01 0010", bus.state_dbg, bus.i_or_d, bus.alu_src_b, bus.alu_control); bad++;
    end
    total++;
    if ({bus.mem_write, bus.ir_write, bus.pc_write_en, bus.reg_write} !== 4'b0000) begin
      $display("FAIL reset_mid_strobes got=%b exp=0000", {bus.mem_write, bus.ir_write, bus.pc_write_en, bus.reg_write}); bad++;
    end
    next();
    reset = 1'b0; bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== 4'd0 || bus.ir_write !== 1'b0) begin
      $display("FAIL reset_release got st=%0d ret=%0d irw=%b exp 0 0 0", bus.state_dbg, bus.retired, bus.ir_write); bad++;
    end
    exp_ret = '0;
    next();
  endtask

  task automatic test_add();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.state_dbg !== exp_st[i]) begin $display("FAIL add_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); bad++; end
      if (i == 2) begin
        total++;
        if (bus.alu_control !== 4'b0010 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
          $display("FAIL add_exec got alu=%b a=%b b=%b exp 0010 1 00", bus.alu_control, bus.alu_src_a, bus.alu_src_b); bad++;
        end
      end
      if (i == 3) begin
        total++;
        if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin
          $display("FAIL add_wb got=%b exp=110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); bad++;
        end
      end
      next();
    end
    exp_ret++;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== exp_ret) begin
      $display("FAIL add_retire got st=%0d ret=%0d exp st=0 ret=%0d", bus.state_dbg, bus.retired, exp_ret); bad++;
    end
  endtask

  task automatic test_sub_funct();
    bus.opcode = 6'b000000; bus.funct = 6'b100010; bus.mem_ready = 1'b1;
    next(); next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd6 || bus.alu_control !== 4'b0110) begin
      $display("FAIL sub_exec got st=%0d alu=%b exp 6 0110", bus.state_dbg, bus.alu_control); bad++;
    end
    bus.funct = 6'b101010;
    #1;
    total++;
    if (bus.alu_control !== 4'b0111) begin $display("FAIL slt_code got=%b exp=0111", bus.alu_control); bad++; end
    bus.funct = 6'b100101;
    #1;
    total++;
    if (bus.alu_control !== 4'b0001) begin $display("FAIL or_code got=%b exp=0001", bus.alu_control); bad++; end
    bus.funct = 6'b100100;
    #1;
    total++;
    if (bus.alu_control !== 4'b0000) begin $display("FAIL and_code got=%b exp=0000", bus.alu_control); bad++; end
    next(); next();
    exp_ret++;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [8];
    logic       rdy    [8];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      total++;
      if (bus.state_dbg !== exp_st[i]) begin $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); bad++; end
      if (i == 2) begin
        total++;
        if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10) begin
          $display("FAIL lw_memadr got a=%b b=%b exp 1 10", bus.alu_src_a, bus.alu_src_b); bad++;
        end
      end
      if (i == 4) begin
        total++;
        if (bus.i_or_d !== 1'b1 || bus.reg_write !== 1'b0) begin
          $display("FAIL lw_memrd got iord=%b rw=%b exp 1 0", bus.i_or_d, bus.reg_write); bad++;
        end
      end
      if (i == 7) begin
        total++;
        if ({bus.mem_to_reg, bus.reg_write, bus.reg_dst} !== 3'b110) begin
          $display("FAIL lw_memwb got=%b exp=110", {bus.mem_to_reg, bus.reg_write, bus.reg_dst}); bad++;
        end
      end
      next();
    end
    exp_ret++;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== exp_ret || bus.mem_timeout !== 1'b0) begin
      $display("FAIL lw_end got st=%0d ret=%0d to=%b exp 0 %0d 0", bus.state_dbg, bus.retired, bus.mem_timeout, exp_ret); bad++;
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5];
    logic       rdy    [5];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      total++;
      if (bus.state_dbg !== exp_st[i]) begin $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); bad++; end
      if (i >= 3) begin
        total++;
        if (bus.mem_write !== 1'b1 || bus.i_or_d !== 1'b1) begin
          $display("FAIL sw_memwr[%0d] got mw=%b iord=%b exp 1 1", i, bus.mem_write, bus.i_or_d); bad++;
        end
      end
      next();
    end
    exp_ret++;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== exp_ret) begin
      $display("FAIL sw_end got st=%0d ret=%0d exp 0 %0d", bus.state_dbg, bus.retired, exp_ret); bad++;
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcw);
    bus.opcode = op; bus.zero = z; bus.mem_ready = 1'b1;
    next(); next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd8 || bus.pc_write_en !== exp_pcw || bus.pc_src !== 2'b01 || bus.alu_control !== 4'b0110) begin
      $display("FAIL branch op=%b z=%b got st=%0d pcw=%b src=%b alu=%b exp 8 %b 01 0110",
               op, z, bus.state_dbg, bus.pc_write_en, bus.pc_src, bus.alu_control, exp_pcw); bad++;
    end
    next();
    exp_ret++;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== exp_ret) begin
      $display("FAIL branch_retire got st=%0d ret=%0d exp 0 %0d", bus.state_dbg, bus.retired, exp_ret); bad++;
    end
  endtask

  task automatic test_addi();
    bus.opcode = 6'b001000; bus.mem_ready = 1'b1;
    next(); next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd9 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.reg_write !== 1'b0) begin
      $display("FAIL addi_ex got st=%0d a=%b b=%b rw=%b exp 9 1 10 0", bus.state_dbg, bus.alu_src_a, bus.alu_src_b, bus.reg_write); bad++;
    end
    next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd10 || {bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b100) begin
      $display("FAIL addi_wb got st=%0d wr/dst/m2r=%b exp 10 100", bus.state_dbg, {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); bad++;
    end
    next();
    exp_ret++;
  endtask

  task automatic test_jump();
    bus.opcode = 6'b000010; bus.mem_ready = 1'b1;
    next(); next();
    #1;
    total++;
    if (bus.state_dbg !== 4'd11 || bus.pc_write_en !== 1'b1 || bus.pc_src !== 2'b10) begin
      $display("FAIL jump got st=%0d pcw=%b src=%b exp 11 1 10", bus.state_dbg, bus.pc_write_en, bus.pc_src); bad++;
    end
    next();
    exp_ret++;
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.retired !== exp_ret) begin
      $display("FAIL jump_retire got st=%0d ret=%0d exp 0 %0d", bus.state_dbg, bus.retired, exp_ret); bad++;
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn, input int ncyc);
    logic [3:0] exp_st;
    logic       saw_rw;
    saw_rw = 1'b0;
    bus.opcode = op; bus.funct = fn; bus.mem_ready = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      exp_st = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd6;
      #1;
      if (bus.reg_write === 1'b1) saw_rw = 1'b1;
      total++;
      if (bus.state_dbg !== exp_st || bus.illegal !== (i == ncyc - 1)) begin
        $display("FAIL illegal[%0d] op=%b fn=%b got st=%0d ill=%b exp %0d %b",
                 i, op, fn, bus.state_dbg, bus.illegal, exp_st, (i == ncyc - 1)); bad++;
      end
      next();
    end
    #1;
    total++;
    if (bus.state_dbg !== 4'd0 || bus.illegal !== 1'b0 || bus.retired !== exp_ret || saw_rw !== 1'b0) begin
      $display("FAIL illegal_end got st=%0d ill=%b ret=%0d rw_seen=%b exp 0 0 %0d 0",
               bus.state_dbg, bus.illegal, bus.retired, saw_rw, exp_ret); bad++;
    end
  endtask

  task automatic test_timeout();
    bus.opcode = 6'b000010; bus.mem_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      #1;
      total++;
      if (bus.state_dbg !== 4'd0 || bus.ir_write !== 1'b0 || bus.mem_timeout !== (k >= MEM_WAIT_MAX)) begin
        $display("FAIL timeout[%0d] got st=%0d irw=%b to=%b exp 0 0 %b",
                 k, bus.state_dbg, bus.ir_write, bus.mem_timeout, (k >= MEM_WAIT_MAX)); bad++;
      end
      next();
    end
    test_jump();
    total++;
    if (bus.mem_timeout !== 1'b1) begin $display("FAIL timeout_sticky got=%b exp=1", bus.mem_timeout); bad++; end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) test_jump();
  endtask

  task automatic test_final_reset();
    reset = 1'b1;
    #1;
    total++;
    if (bus.mem_timeout !== 1'b0 || bus.retired !== 4'd0 || bus.state_dbg !== 4'd0) begin
      $display("FAIL final_reset got to=%b ret=%0d st=%0d exp 0 0 0", bus.mem_timeout, bus.retired, bus.state_dbg); bad++;
    end
    next();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_funct();
    test_lw();
    test_sw();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_addi();
    test_jump();
    test_illegal(6'b111111, 6'b000000, 2);
    test_illegal(6'b000000, 6'b000001, 3);
`ifdef MIPS_CTRL_BNE_EN
    test_branch(6'b000101, 1'b0, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
`else
    test_illegal(6'b000101, 6'b000000, 2);
`endif
    test_timeout();
    test_back_to_back();
    test_final_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
